mem_upload: RTL and testbench

- Responder for the HPS ioctl upload (save) direction; the counterpart of the ROM/expansion download path that writes into SDRAM.
- Serves HPS byte reads (ioctl_rd / ioctl_addr) from a selected 16 KB-aligned SDRAM page window.
- Reads go through a req/ack port into the sdram arbiter. A one-entry sequential prefetch buffer lets streaming reads complete without wait states.
- Sits beside hps_io and muxes into the sdram address/oe path while an upload is in progress.

---
 rtl/mem_upload.sv | 218 +++++++++++++++++++++
 tb/tb_mem_upload.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_upload.sv
// HPS ioctl upload responder: serves byte reads from a 16 KB-aligned SDRAM window
// through a req/ack port, with a one-entry sequential prefetch buffer.
module mem_upload #(
  parameter int          SIZE_LOG2 = 14,
  parameter logic [7:0]  FILL      = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_ref,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  input  logic [8:0]  base_page,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_dout,
  output logic        active
);

  localparam int PAGE_LOG2 = 14;

  typedef enum logic [1:0] {IDLE, WAIT_CE, FETCH, DONE} state_e;

  logic [1:0]  rst_sync_q;
  logic        rst_n;

  state_e      state_q, state_d;
  logic        upload_q;
  logic [8:0]  page_q, page_d;
  logic [24:0] pf_addr_q, pf_addr_d;
  logic [7:0]  pf_data_q, pf_data_d;
  logic        pf_valid_q, pf_valid_d;
  logic [24:0] pend_addr_q, pend_addr_d;
  logic        pend_q, pend_d;
  logic [24:0] fetch_addr_q, fetch_addr_d;
  logic        drop_q, drop_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic        req_q, req_d;
  logic [22:0] addr_q, addr_d;
  logic        active_q, active_d;

  logic        rd_accept, rd_in_range, rd_hit, rd_next_ok, upload_rise;
  logic [24:0] rd_next;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign upload_rise = ioctl_upload && !upload_q;
  assign rd_accept   = ioctl_rd && ioctl_upload && upload_q && !wait_q;
  assign rd_in_range = (ioctl_addr[24:SIZE_LOG2] == '0);
  assign rd_hit      = pf_valid_q && (ioctl_addr == pf_addr_q);
  assign rd_next     = ioctl_addr + 25'd1;
  assign rd_next_ok  = (ioctl_addr[SIZE_LOG2-1:0] != {SIZE_LOG2{1'b1}});

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    state_d      = state_q;
    page_d       = page_q;
    pf_addr_d    = pf_addr_q;
    pf_data_d    = pf_data_q;
    pf_valid_d   = pf_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_d       = pend_q;
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;
    din_d        = din_q;
    wait_d       = wait_q;
    req_d        = req_q;
    addr_d       = addr_q;
    active_d     = active_q;

    if (state_q == DONE) state_d = IDLE;

    if (rd_accept) begin
      if (!rd_in_range) begin
        din_d = FILL;
      end else if (state_q == FETCH) begin
        wait_d      = 1'b1;
        pend_d      = 1'b1;
        pend_addr_d = ioctl_addr;
      end else if (rd_hit) begin
        din_d = pf_data_q;
        if (rd_next_ok) begin
          fetch_addr_d = rd_next;
          state_d      = WAIT_CE;
        end
      end else begin
        wait_d       = 1'b1;
        pend_d       = 1'b1;
        pend_addr_d  = ioctl_addr;
        fetch_addr_d = ioctl_addr;
        state_d      = WAIT_CE;
      end
    end

    // Ack handling looks at pend_d so a read landing in the ack cycle is resolved here.
    case (state_q)
      WAIT_CE: begin
        if (ce_ref && ioctl_upload) begin
          req_d   = 1'b1;
          addr_d  = {page_q, {PAGE_LOG2{1'b0}}} + 23'(fetch_addr_d[SIZE_LOG2-1:0]);
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          req_d  = 1'b0;
          drop_d = 1'b0;
          if (drop_q || !ioctl_upload) begin
            if (ioctl_upload) begin
              fetch_addr_d = pend_d ? pend_addr_d : fetch_addr_q;
              state_d      = WAIT_CE;
            end else begin
              state_d  = IDLE;
              active_d = 1'b0;
            end
          end else if (pend_d) begin
            if (pend_addr_d == fetch_addr_q) begin
              din_d  = mem_dout;
              wait_d = 1'b0;
              pend_d = 1'b0;
              if (pend_addr_d[SIZE_LOG2-1:0] != {SIZE_LOG2{1'b1}}) begin
                fetch_addr_d = pend_addr_d + 25'd1;
                state_d      = WAIT_CE;
              end else begin
                state_d = DONE;
              end
            end else begin
              fetch_addr_d = pend_addr_d;
              state_d      = WAIT_CE;
            end
          end else begin
            pf_data_d  = mem_dout;
            pf_addr_d  = fetch_addr_q;
            pf_valid_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      default: ;
    endcase

    if (upload_rise) begin
      page_d       = base_page;
      pf_valid_d   = 1'b0;
      active_d     = 1'b1;
      pend_d       = 1'b0;
      wait_d       = 1'b0;
      fetch_addr_d = '0;
      if (state_d == FETCH) drop_d  = 1'b1;
      else                  state_d = WAIT_CE;
    end

    if (!ioctl_upload) begin
      pf_valid_d = 1'b0;
      pend_d     = 1'b0;
      wait_d     = 1'b0;
      if (state_d == FETCH) begin
        drop_d = 1'b1;
      end else begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      upload_q     <= 1'b0;
      page_q       <= '0;
      pf_addr_q    <= '0;
      pf_data_q    <= '0;
      pf_valid_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_q       <= 1'b0;
      fetch_addr_q <= '0;
      drop_q       <= 1'b0;
      din_q        <= FILL;
      wait_q       <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      active_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q      <= state_d;
      upload_q     <= ioctl_upload;
      page_q       <= page_d;
      pf_addr_q    <= pf_addr_d;
      pf_data_q    <= pf_data_d;
      pf_valid_q   <= pf_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_q       <= pend_d;
      fetch_addr_q <= fetch_addr_d;
      drop_q       <= drop_d;
      din_q        <= din_d;
      wait_q       <= wait_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      active_q     <= active_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign active     = active_q;

endmodule

// File: tb/tb_mem_upload.sv
// Bench for mem_upload: directed upload scenarios plus randomized reads checked
// against an address-arithmetic model of the SDRAM window.
module tb_mem_upload;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_ref = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [8:0]  base_page = '0;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic        active;

  mem_upload dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_ref(ce_ref),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .base_page(base_page),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_dout(mem_dout), .active(active)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          hold_ack = 1'b0;
  bit          ce_random = 1'b0;
  bit          mem_hash = 1'b0;
  int          max_lat = 3;
  int          req_count = 0;
  int          wait_cycles = 0;
  int          addr_bad = 0;
  logic [22:0] last_ack_addr = '0;
  logic [8:0]  cur_page = '0;

  // SDRAM content: plain k^5A for directed tests, an address hash for the random phase.
  function automatic logic [7:0] mem_byte(input logic [22:0] a);
    if (mem_hash) return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] expect_byte(input logic [24:0] a);
    if (a >= 25'd16384) return 8'hFF;
    return mem_byte(23'(cur_page) * 23'd16384 + 23'(a));
  endfunction

  // SDRAM responder and monitor.
  initial begin
    int   cnt = 0;
    int   lat = 0;
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (mem_req && !prev_req) begin
        req_count++;
        if (mem_addr[22:14] !== cur_page) addr_bad++;
      end
      prev_req = mem_req;
      if (ioctl_wait) wait_cycles++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && !hold_ack) begin
        if (cnt >= lat) begin
          mem_ack       = 1'b1;
          mem_dout      = mem_byte(mem_addr);
          last_ack_addr = mem_addr;
          cnt           = 0;
          lat           = $urandom_range(0, max_lat);
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(negedge clk_sys);
      ph++;
      ce_ref = ce_random ? ($urandom_range(0, 2) == 0) : (ph % 4 == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic hps_read(input logic [24:0] a, output logic [7:0] d, output bit waited);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    waited   = ioctl_wait;
    for (int i = 0; i < 300 && ioctl_wait; i++) @(negedge clk_sys);
    check("read_timeout", ioctl_wait, 1'b0);
    d = ioctl_din;
  endtask

  task automatic rd_pulse(input logic [24:0] a);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 200 && !mem_req; i++) @(negedge clk_sys);
    check(tag, mem_req, 1'b1);
  endtask

  task automatic wait_unwait(input string tag);
    for (int i = 0; i < 300 && ioctl_wait; i++) @(negedge clk_sys);
    check(tag, ioctl_wait, 1'b0);
  endtask

  task automatic start_upload(input logic [8:0] p);
    @(negedge clk_sys);
    base_page    = p;
    cur_page     = p;
    ioctl_upload = 1'b1;
  endtask

  task automatic stop_upload();
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    for (int i = 0; i < 200 && active; i++) @(negedge clk_sys);
    check("stop_active", active, 1'b0);
  endtask

  initial begin
    logic [7:0]  d;
    bit          w;
    int          rc;
    logic [24:0] a;
    logic [24:0] last_a;
    logic [8:0]  rpage;

    // Reset state
    cycles(3);
    reset_n = 1'b1;
    cycles(4);
    check("rst_din", ioctl_din, 8'hFF);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 23'h0);
    check("rst_active", active, 1'b0);

    // Sequential streaming from the prefetch buffer
    start_upload(9'h1FF);
    cycles(1);
    check("start_active", active, 1'b1);
    cycles(20);
    wait_cycles = 0;
    for (int k = 0; k < 16; k++) begin
      hps_read(25'(k), d, w);
      check("seq_din", d, 8'(k) ^ 8'h5A);
      check("seq_wait", w, 1'b0);
      cycles(18);
    end
    check("seq_no_wait", wait_cycles, 0);

    // Random miss right after a hit
    stop_upload();
    start_upload(9'h1FF);
    cycles(20);
    hps_read(25'h0, d, w);
    check("hit0_din", d, 8'h5A);
    check("hit0_wait", w, 1'b0);
    hps_read(25'h0123, d, w);
    check("miss_waited", w, 1'b1);
    check("miss_din", d, 8'h79);
    check("miss_addr", mem_addr, 23'h7FC123);
    wait_req("miss_next_req");
    check("miss_next_addr", mem_addr, 23'h7FC124);

    // Out-of-range read
    cycles(20);
    rc = req_count;
    hps_read(25'h4000, d, w);
    check("oor_din", d, 8'hFF);
    check("oor_wait", w, 1'b0);
    cycles(10);
    check("oor_no_req", req_count, rc);
    check("oor_req_low", mem_req, 1'b0);
    hps_read(25'h0124, d, w);
    check("oor_pf_kept_wait", w, 1'b0);
    check("oor_pf_kept_din", d, 8'h7E);

    // Collision with an in-flight prefetch
    cycles(20);
    stop_upload();
    start_upload(9'h1FF);
    cycles(20);
    hold_ack = 1'b1;
    hps_read(25'h0, d, w);
    check("col_hit_din", d, 8'h5A);
    wait_req("col_pf_req");
    check("col_pf_addr", mem_addr, 23'h7FC001);
    rd_pulse(25'h0200);
    check("col_wait", ioctl_wait, 1'b1);
    rc = req_count;
    cycles(3);
    hold_ack = 1'b0;
    wait_unwait("col_done");
    check("col_ack_addr", last_ack_addr, 23'h7FC200);
    check("col_din", ioctl_din, 8'h5A);
    check("col_req_count", req_count - rc, 1);

    // Abort while a request is in flight
    cycles(20);
    hold_ack = 1'b1;
    rd_pulse(25'h0300);
    wait_req("abort_req");
    check("abort_addr", mem_addr, 23'h7FC300);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort_wait", ioctl_wait, 1'b0);
    check("abort_req_held", mem_req, 1'b1);
    check("abort_active_held", active, 1'b1);
    cycles(5);
    check("abort_req_still", mem_req, 1'b1);
    hold_ack = 1'b0;
    for (int i = 0; i < 50 && mem_req; i++) @(negedge clk_sys);
    check("abort_req_drop", mem_req, 1'b0);
    check("abort_inactive", active, 1'b0);
    rc = req_count;
    cycles(20);
    check("abort_no_more_req", req_count, rc);
    check("abort_still_inactive", active, 1'b0);

    // Asynchronous reset mid-fetch
    start_upload(9'h0A3);
    cycles(20);
    hold_ack = 1'b1;
    rd_pulse(25'h0050);
    wait_req("arst_req");
    check("arst_wait_before", ioctl_wait, 1'b1);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wait", ioctl_wait, 1'b0);
    check("arst_req", mem_req, 1'b0);
    check("arst_active", active, 1'b0);
    check("arst_din", ioctl_din, 8'hFF);
    hold_ack     = 1'b0;
    ioctl_upload = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(4);

    // Randomized reads against the window model
    mem_hash  = 1'b1;
    ce_random = 1'b1;
    max_lat   = 4;
    rpage     = 9'($urandom_range(0, 511));
    start_upload(rpage);
    cycles(20);
    addr_bad = 0;
    last_a   = '0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = last_a + 25'd1;
        5, 6, 7:       a = 25'($urandom_range(0, 16383));
        8:             a = 25'($urandom_range(16380, 16385));
        default:       a = 25'($urandom);
      endcase
      hps_read(a, d, w);
      check("rand_din", d, expect_byte(a));
      last_a = a;
      cycles($urandom_range(0, 5));
    end
    check("rand_addr_window", addr_bad, 0);
    stop_upload();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
